checker_mem_loader: RTL and testbench
=====================================

Name: checker_mem_loader

Overview:
- Write-side master for the checker byte memory (2048 x 8, 32-bit data ports, single-byte one-hot write enables).
- Accepts a burst of 32-bit words over a valid/ready stream and issues one write cycle per byte lane at consecutive word slots.
- Optionally reads each word back and compares it against the written value.
- Sits between the checker control logic and one memory port.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit word slots in the memory; word index wraps modulo this value; power of two.
- IDX_W, 9, width of the word index; equals log2(DEPTH_WORDS).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle burst request; ignored unless the block is idle.
- base  in  IDX_W  first word index; sampled when start is accepted.
- count  in  IDX_W+1  number of words in the burst; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at burst end.
- s_data  in  32  stream word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  block accepts s_data this cycle.
- mem_addr  out  16  memory address: {1'b0, byte_index[11:0], 3'b000}, where byte_index = word_index*4.
- mem_di  out  32  memory write data.
- mem_we  out  4  one-hot byte write enable.
- mem_do  in  32  memory read data; registered, one cycle latency.
- err  out  1  sticky verify mismatch flag (CHECKER_MEM_VERIFY_EN only; tied 0 otherwise).
- err_idx  out  IDX_W  word index of the first mismatch (CHECKER_MEM_VERIFY_EN only; tied 0 otherwise).

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, mem_addr=0, mem_di=0, mem_we=0, err=0, err_idx=0; state IDLE.
- Reset mid-burst aborts at once: no further writes, no done pulse, and partially written bytes are left as written.
- All outputs are registered.
- IDLE: on start=1:
  - Latch base into the word index and count into the remaining counter.
  - If count=0, go to DONE; otherwise go to WAIT.
- WAIT: s_ready=1, mem_we=0.
  - On s_valid & s_ready, latch s_data into mem_di and go to WR with lane=0.
  - With s_valid low, stay in WAIT indefinitely.
- WR: one cycle per lane, lane 0..3.
  - mem_we = 4'b0001 << lane; mem_addr is taken from the current word index; mem_di holds the whole word, and the memory selects the byte.
  - After lane 3, advance as follows:
    - Verify enabled: go to VRD.
    - Verify disabled: increment the word index modulo DEPTH_WORDS and decrement the remaining counter; go to WAIT if remaining > 0, else DONE.
- mem_we is never multi-hot. The memory ignores non-one-hot enables, so this is a hard invariant.
- s_ready is low in every state except WAIT. A word presented while the block is in WR is held by the producer.
- Throughput: 5 cycles per word without verify (accept + 4 writes); 7 cycles with verify.
- Word index wrap example: base=511, count=2 writes words 511 then 0.
- DONE: done=1 for one cycle, busy=0 on the following cycle, then return to IDLE.
- start while busy is ignored and has no side effects.
- start in the same cycle that done is high is ignored; start is accepted from IDLE only.
- busy stays low throughout a count=0 burst; done pulses 2 cycles after start.

Optional Feature:
- Macro: CHECKER_MEM_VERIFY_EN.
- Defined:
  - VRD: mem_we=0 with mem_addr held for one cycle.
  - VCMP: compare mem_do with mem_di.
  - On mismatch while err=0: set err=1 and err_idx=current word index. Later mismatches do not update err_idx.
  - After VCMP, advance the index and counter exactly as after lane 3 with verify disabled.
  - err clears only on reset or on an accepted start.
  - The burst continues after a mismatch.
- Undefined: the VRD and VCMP states are absent; err and err_idx are constant 0.

Test Plan:
- Basic burst: base=0, count=1, s_data=32'hA1B2C3D4 presented continuously -> mem_we sequence 1,2,4,8 at mem_addr=16'h0000; memory bytes 0..3 = D4,C3,B2,A1; done pulses 6 cycles after the s_ready handshake cycle (non-verify build).
- Backpressure: count=3, s_valid gaps of 0, 3 and 7 cycles -> exactly 12 single-lane writes; mem_addr steps 16'h0000, 16'h0020, 16'h0040; s_ready is never high during WR.
- Wrap and edge: base=511, count=2 -> writes at mem_addr 16'h3FE0 then 16'h0000. count=0 -> done pulses 2 cycles after start with no writes.
- Ignored start and reset: start pulsed mid-burst -> no restart, index unchanged. sys_rst_n=0 during WR lane 2 -> mem_we=0 and busy=0 next cycle; lanes 0..1 written, lanes 2..3 unchanged.
- Verify (CHECKER_MEM_VERIFY_EN): memory model corrupts byte 1 of word index 5 in a count=8 burst from base 0 -> err=1, err_idx=5; all 8 words still written; next accepted start clears err.

Source files
------------

// File: rtl/checker_mem_loader_if.sv
// Stream and memory-port bundle for the checker memory loader.
//
// Purpose: carries the 32-bit valid/ready word stream and the write/read port
// of the checker byte memory (2048 x 8, 32-bit data, one-hot byte enables).
//
// Signals:
//   s_data   [31:0]  stream word
//   s_valid          stream word valid
//   s_ready          loader accepts s_data this cycle
//   mem_addr [15:0]  {1'b0, byte_index[11:0], 3'b000}
//   mem_di   [31:0]  write data (memory selects the byte by mem_we)
//   mem_we   [3:0]   one-hot byte write enable
//   mem_do   [31:0]  registered read data, one cycle latency
//
// Modports:
//   master - the loader (drives s_ready and the memory request)
//   slave  - producer/memory side
interface checker_mem_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_di;
  logic [3:0]  mem_we;
  logic [31:0] mem_do;

  modport master (
    input  s_data, s_valid, mem_do,
    output s_ready, mem_addr, mem_di, mem_we
  );

  modport slave (
    output s_data, s_valid, mem_do,
    input  s_ready, mem_addr, mem_di, mem_we
  );
endinterface

// File: rtl/checker_mem_loader.sv
// Write-side master for the checker byte memory.
//
// Accepts a burst of 32-bit words over a valid/ready stream and writes each
// word into consecutive word slots, one single-byte write cycle per lane.
// The word index wraps modulo DEPTH_WORDS.
//
// Build option: define CHECKER_MEM_VERIFY_EN to read every word back after
// its four lane writes and compare it with the written value; the first
// mismatching word index is captured in err_idx and err stays set until
// reset or the next accepted start. Without the macro err/err_idx are 0.
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   start      one-cycle burst request, accepted only when idle
//   base       first word index (sampled on accepted start)
//   count      number of words in the burst (sampled on accepted start)
//   busy       high from the cycle after start until done
//   done       one-cycle pulse at burst end
//   err        sticky readback mismatch flag
//   err_idx    word index of the first mismatch
//   bus        stream + memory port (checker_mem_loader_if.master)
//
// All outputs are registered.
module checker_mem_loader #(
  parameter int DEPTH_WORDS = 512,
  parameter int IDX_W       = 9
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     base,
  input  logic [IDX_W:0]       count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx,
  checker_mem_loader_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef CHECKER_MEM_VERIFY_EN
  localparam logic [2:0] S_VRD  = 3'd4;
  localparam logic [2:0] S_VCMP = 3'd5;
`endif

  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [IDX_W:0]   LAST_WORD = (IDX_W+1)'(1);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   remaining;
  logic [1:0]       lane;

  // Word index -> memory address: byte_index = idx*4, placed at bits [14:3].
  function automatic logic [15:0] word_addr(input logic [IDX_W-1:0] w);
    logic [11:0] byte_idx;
    byte_idx = 12'(w) << 2;
    return {1'b0, byte_idx, 3'b000};
  endfunction

`ifndef CHECKER_MEM_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^bus.mem_do;
  assign err       = 1'b0;
  assign err_idx   = '0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.s_ready  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_di   <= '0;
      bus.mem_we   <= '0;
      lane         <= '0;
      remaining    <= '0;
`ifdef CHECKER_MEM_VERIFY_EN
      err          <= 1'b0;
      err_idx      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // A start coinciding with the done pulse belongs to the old burst.
          if (start && !done) begin
            idx       <= base;
            remaining <= count;
`ifdef CHECKER_MEM_VERIFY_EN
            err       <= 1'b0;
            err_idx   <= '0;
`endif
            if (count == '0) begin
              state <= S_DONE;
            end else begin
              state       <= S_WAIT;
              busy        <= 1'b1;
              bus.s_ready <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (bus.s_valid && bus.s_ready) begin
            bus.mem_di   <= bus.s_data;
            bus.mem_addr <= word_addr(idx);
            bus.mem_we   <= 4'b0001;
            bus.s_ready  <= 1'b0;
            lane         <= 2'd0;
            state        <= S_WR;
          end
        end

        S_WR: begin
          if (lane == 2'd3) begin
            bus.mem_we <= 4'b0000;
`ifdef CHECKER_MEM_VERIFY_EN
            state      <= S_VRD;
`else
            idx       <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LAST_WORD) begin
              state <= S_DONE;
            end else begin
              state       <= S_WAIT;
              bus.s_ready <= 1'b1;
            end
`endif
          end else begin
            // Shifting the single set bit keeps the enable one-hot.
            lane       <= lane + 1'b1;
            bus.mem_we <= {bus.mem_we[2:0], 1'b0};
          end
        end

`ifdef CHECKER_MEM_VERIFY_EN
        // Address held with no enable; the read word arrives next cycle.
        S_VRD: begin
          state <= S_VCMP;
        end

        S_VCMP: begin
          if ((bus.mem_do != bus.mem_di) && !err) begin
            err     <= 1'b1;
            err_idx <= idx;
          end
          idx       <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == LAST_WORD) begin
            state <= S_DONE;
          end else begin
            state       <= S_WAIT;
            bus.s_ready <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checker_mem_loader.sv
// Directed bench for checker_mem_loader: byte-memory model on the slave side
// of the interface, a write monitor, and a linear directed stimulus sequence.
module tb_checker_mem_loader;

`ifdef CHECKER_MEM_VERIFY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic [8:0] base;
  logic [9:0] count;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] err_idx;

  checker_mem_loader_if bus_if ();

  checker_mem_loader #(.DEPTH_WORDS(512), .IDX_W(9)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .bus       (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Byte memory model: 2048 x 8, one-hot byte enables, registered read.
  logic [7:0]  mem [0:2047];
  logic        fill;
  logic        corrupt_en;
  logic [10:0] ba;
  assign ba = bus_if.mem_addr[13:3];

  always @(posedge sys_clk) begin
    if (fill) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h5A;
    end else if ($onehot(bus_if.mem_we)) begin
      for (int l = 0; l < 4; l++) begin
        if (bus_if.mem_we[l]) begin
          if (corrupt_en && ba == 11'd20 && l == 1)
            mem[ba + 11'(l)] <= ~bus_if.mem_di[8*l +: 8];
          else
            mem[ba + 11'(l)] <= bus_if.mem_di[8*l +: 8];
        end
      end
    end
    bus_if.mem_do <= {mem[ba + 11'd3], mem[ba + 11'd2], mem[ba + 11'd1], mem[ba]};
  end

  // Write monitor
  int          n_wr = 0;
  int          n_multi = 0;
  int          n_rdy_wr = 0;
  int          n_log = 0;
  logic [15:0] addr_log [0:63];

  always @(posedge sys_clk) begin
    if (bus_if.mem_we != 4'b0000) begin
      n_wr <= n_wr + 1;
      if (!$onehot(bus_if.mem_we)) n_multi <= n_multi + 1;
      if (bus_if.s_ready) n_rdy_wr <= n_rdy_wr + 1;
      if (bus_if.mem_we == 4'b0001 && n_log < 64) begin
        addr_log[n_log[5:0]] <= bus_if.mem_addr;
        n_log <= n_log + 1;
      end
    end
  end

  function automatic logic [31:0] mem_word(input int w);
    return {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] data, input int gap);
    int n;
    bus_if.s_valid = 1'b0;
    repeat (gap) tick();
    bus_if.s_data  = data;
    bus_if.s_valid = 1'b1;
    n = 0;
    while (bus_if.s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("accept", bus_if.s_ready, 1);
    tick();
    bus_if.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(tag, done, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   wr0;
    int   log0;
    logic seen;

    sys_rst_n      = 1'b0;
    start          = 1'b0;
    base           = '0;
    count          = '0;
    bus_if.s_data  = '0;
    bus_if.s_valid = 1'b0;
    fill           = 1'b1;
    corrupt_en     = 1'b0;
    tick();
    fill = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_s_ready", bus_if.s_ready, 0);
    check("rst_addr",    bus_if.mem_addr, 0);
    check("rst_di",      bus_if.mem_di, 0);
    check("rst_we",      bus_if.mem_we, 0);
    check("rst_err",     err, 0);
    check("rst_err_idx", err_idx, 0);
    sys_rst_n = 1'b1;
    tick();

    // Basic burst: one word at index 0, data presented continuously
    wr0            = n_wr;
    base           = 9'd0;
    count          = 10'd1;
    bus_if.s_data  = 32'hA1B2C3D4;
    bus_if.s_valid = 1'b1;
    start          = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy",  busy, 1);
    check("t1_ready", bus_if.s_ready, 1);
    for (int l = 0; l < 4; l++) begin
      tick();
      check("t1_we",    bus_if.mem_we, 32'd1 << l);
      check("t1_addr",  bus_if.mem_addr, 32'h0000);
      check("t1_di",    bus_if.mem_di, 32'hA1B2C3D4);
      check("t1_ready_wr", bus_if.s_ready, 0);
    end
    for (int i = 0; i < EXTRA; i++) begin
      tick();
      check("t1_pre_done", done, 0);
    end
    tick();
    check("t1_done",         done, 1);
    check("t1_busy_at_done", busy, 1);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);
    bus_if.s_valid = 1'b0;
    check("t1_mem",    mem_word(0), 32'hA1B2C3D4);
    check("t1_writes", n_wr - wr0, 4);

    // Backpressure: three words with valid gaps of 0, 3 and 7 cycles
    wr0   = n_wr;
    log0  = n_log;
    n     = n_rdy_wr;
    base  = 9'd0;
    count = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 3);
    send_word(32'h99AABBCC, 7);
    wait_done("t2_done", 40);
    check("t2_writes",  n_wr - wr0, 12);
    check("t2_addr0",   addr_log[log0],     16'h0000);
    check("t2_addr1",   addr_log[log0 + 1], 16'h0020);
    check("t2_addr2",   addr_log[log0 + 2], 16'h0040);
    check("t2_ready_in_wr", n_rdy_wr - n, 0);
    check("t2_mem1",    mem_word(1), 32'h55667788);
    check("t2_mem2",    mem_word(2), 32'h99AABBCC);

    // Wrap: base=511, count=2 writes word 511 then word 0
    log0  = n_log;
    base  = 9'd511;
    count = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'hDEADBEEF, 0);
    send_word(32'h0BADF00D, 0);
    wait_done("t3_done", 40);
    check("t3_addr0", addr_log[log0],     16'h3FE0);
    check("t3_addr1", addr_log[log0 + 1], 16'h0000);
    check("t3_mem511", mem_word(511), 32'hDEADBEEF);
    check("t3_mem0",   mem_word(0),   32'h0BADF00D);

    // count=0: done two cycles after start, busy stays low, no writes
    wr0   = n_wr;
    base  = 9'd7;
    count = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy1", busy, 0);
    check("t4_done1", done, 0);
    tick();
    check("t4_busy2", busy, 0);
    check("t4_done2", done, 1);
    // start in the done cycle is ignored
    count = 10'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_start_at_done", busy, 0);
    tick();
    check("t4_still_idle", bus_if.s_ready, 0);
    check("t4_writes", n_wr - wr0, 0);

    // Start pulsed mid-burst is ignored
    wr0   = n_wr;
    log0  = n_log;
    base  = 9'd8;
    count = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'h0F0F0F0F, 0);
    base  = 9'd100;
    count = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy", busy, 1);
    send_word(32'hF0F0F0F0, 0);
    wait_done("t5_done", 40);
    check("t5_writes", n_wr - wr0, 8);
    check("t5_addr0",  addr_log[log0],     16'h0100);
    check("t5_addr1",  addr_log[log0 + 1], 16'h0120);
    check("t5_mem100", mem_word(100), 32'h5A5A5A5A);

    // Reset taking effect where lane 2 would start
    base           = 9'd40;
    count          = 10'd1;
    bus_if.s_data  = 32'h13579BDF;
    bus_if.s_valid = 1'b1;
    start          = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (bus_if.mem_we !== 4'b0010 && n < 20) begin
      tick();
      n++;
    end
    check("t6_lane1", bus_if.mem_we, 4'b0010);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n      = 1'b1;
    bus_if.s_valid = 1'b0;
    check("t6_we",   bus_if.mem_we, 0);
    check("t6_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | done | (bus_if.mem_we != 4'b0000);
    end
    check("t6_no_done_no_write", seen, 0);
    check("t6_mem40", mem_word(40), 32'h5A5A9BDF);
    check("t6_multihot", n_multi, 0);

`ifdef CHECKER_MEM_VERIFY_EN
    // Readback compare with byte 1 of word 5 corrupted by the memory
    wr0        = n_wr;
    corrupt_en = 1'b1;
    base       = 9'd0;
    count      = 10'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'hC0DE0000 + 32'(i), 0);
    wait_done("t7_done", 60);
    corrupt_en = 1'b0;
    check("t7_err",     err, 1);
    check("t7_err_idx", err_idx, 5);
    check("t7_writes",  n_wr - wr0, 32);
    check("t7_mem7",    mem_word(7), 32'hC0DE0007);
    count = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_err_clear", err, 0);
    tick();
    tick();
`else
    check("t7_err_tied",     err, 0);
    check("t7_err_idx_tied", err_idx, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
